// File: rtl/snow64_instr_decoder_pkg.sv
// Shared types and encoding constants for the Snow64 instruction decoder.
// Field positions and per-group opcode limits live here so the decoder and its users agree.
// No logic; no latency; no flow control.
package PkgSnow64Cpu;
    localparam int WIDTH__CPU_ADDR = 64;
endpackage

package PkgSnow64InstrDecoder;
    import PkgSnow64Cpu::*;

    localparam int WIDTH__INSTR   = 32;
    localparam int WIDTH__IMM     = WIDTH__CPU_ADDR;
    localparam int WIDTH__IMM_RAW = 12;

    localparam int POS_GROUP_HI   = 31;
    localparam int POS_GROUP_LO   = 28;
    localparam int POS_RA_HI      = 27;
    localparam int POS_RA_LO      = 24;
    localparam int POS_RB_HI      = 23;
    localparam int POS_RB_LO      = 20;
    localparam int POS_RC_HI      = 19;
    localparam int POS_RC_LO      = 16;
    localparam int POS_OPCODE_HI  = 15;
    localparam int POS_OPCODE_LO  = 12;
    localparam int POS_OP_TYPE_HI = 11;
    localparam int POS_OP_TYPE_LO = 9;
    localparam int POS_IMM_HI     = 11;
    localparam int POS_IMM_LO     = 0;

    localparam logic [3:0] MAX_OPCODE_ALU_FPU   = 4'd13;
    localparam logic [3:0] MAX_OPCODE_CTRL_FLOW = 4'd5;
    localparam logic [3:0] MAX_OPCODE_LOAD      = 4'd15;
    localparam logic [3:0] MAX_OPCODE_STORE     = 4'd15;

    typedef enum logic [1:0] {
        GrpAluFpu   = 2'd0,
        GrpCtrlFlow = 2'd1,
        GrpLoad     = 2'd2,
        GrpStore    = 2'd3
    } Snow64InstrGrp_t;

    typedef struct packed {
        Snow64InstrGrp_t        group;
        logic [3:0]             ra_index;
        logic [3:0]             rb_index;
        logic [3:0]             rc_index;
        logic [3:0]             opcode;
        logic [2:0]             op_type;
        logic [WIDTH__IMM-1:0]  signext_imm;
        logic                   nop;
    } PortOut_InstrDecoder;

    function automatic logic [3:0] max_opcode(input Snow64InstrGrp_t grp);
        case (grp)
            GrpAluFpu:   return MAX_OPCODE_ALU_FPU;
            GrpCtrlFlow: return MAX_OPCODE_CTRL_FLOW;
            GrpLoad:     return MAX_OPCODE_LOAD;
            default:     return MAX_OPCODE_STORE;
        endcase
    endfunction
endpackage

// File: rtl/snow64_instr_decode_comb.sv
// Combinational decode of one raw Snow64 instruction word into PortOut_InstrDecoder.
// Latency: zero (pure combinational).
// Backpressure: none; output always reflects the current input.
module snow64_instr_decode_comb
    import PkgSnow64InstrDecoder::*;
(
    input  logic [WIDTH__INSTR-1:0] in,
    output PortOut_InstrDecoder     out
);

    logic [3:0]      grp4;
    logic [3:0]      opcode;
    Snow64InstrGrp_t grp;
    logic            legal;

    always_comb begin
        grp4   = in[POS_GROUP_HI:POS_GROUP_LO];
        opcode = in[POS_OPCODE_HI:POS_OPCODE_LO];
        grp    = Snow64InstrGrp_t'(grp4[1:0]);
        legal  = (grp4[3:2] == 2'b00) && (opcode <= max_opcode(grp));

        // Illegal words collapse to a bubble with only nop set.
        out = '0;
        if (!legal) begin
            out.nop = 1'b1;
        end else begin
            out.group    = grp;
            out.ra_index = in[POS_RA_HI:POS_RA_LO];
            out.rb_index = in[POS_RB_HI:POS_RB_LO];
            out.rc_index = in[POS_RC_HI:POS_RC_LO];
            out.opcode   = opcode;
            if (grp == GrpAluFpu) begin
                out.op_type = in[POS_OP_TYPE_HI:POS_OP_TYPE_LO];
            end else begin
                out.signext_imm = {{(WIDTH__IMM - WIDTH__IMM_RAW){in[POS_IMM_HI]}},
                                   in[POS_IMM_HI:POS_IMM_LO]};
            end
        end
    end

endmodule

// File: rtl/snow64_instr_decoder.sv
// Snow64 instruction decoder: combinational decode plus a registered copy with valid flag.
// Latency: out is zero-cycle; out_q/out_q_valid are one cycle after in/in_valid.
// Backpressure: none; every valid input is captured on the next edge.
module snow64_instr_decoder
    import PkgSnow64InstrDecoder::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH__INSTR-1:0] in,
    input  logic                    in_valid,
    output PortOut_InstrDecoder     out,
    output PortOut_InstrDecoder     out_q,
    output logic                    out_q_valid
);

    PortOut_InstrDecoder dec_d;
    PortOut_InstrDecoder dec_q;
    logic                dec_vld_d;
    logic                dec_vld_q;

    snow64_instr_decode_comb u_decode_comb (
        .in  (in),
        .out (out)
    );

    // Registered decode holds across invalid cycles; only the flag drops.
    always_comb begin
        dec_d     = dec_q;
        dec_vld_d = 1'b0;
        if (rst) begin
            dec_d = '0;
        end else if (in_valid) begin
            dec_d     = out;
            dec_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        dec_q     <= dec_d;
        dec_vld_q <= dec_vld_d;
    end

    assign out_q       = dec_q;
    assign out_q_valid = dec_vld_q;

endmodule

// File: tb/tb_snow64_instr_decoder.sv
// Self-checking bench for snow64_instr_decoder: hand-derived vectors, random words, registered path.
module tb_snow64_instr_decoder;

    logic        clk;
    logic        rst;
    logic [31:0] dut_in;
    logic        in_valid;
    logic [85:0] out;
    logic [85:0] out_q;
    logic        out_q_valid;

    int checks;
    int errors;

    logic [85:0] exp_q[$];

    localparam logic [85:0] NOP_BUBBLE = {85'd0, 1'b1};

    snow64_instr_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .in          (dut_in),
        .in_valid    (in_valid),
        .out         (out),
        .out_q       (out_q),
        .out_q_valid (out_q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [85:0] model(input logic [31:0] w);
        logic [3:0] g;
        logic [3:0] op;
        bit         ok;
        g  = w[31:28];
        op = w[15:12];
        ok = (g == 4'd0 && op <= 4'd13) || (g == 4'd1 && op <= 4'd5) ||
             (g == 4'd2) || (g == 4'd3);
        if (!ok) return NOP_BUBBLE;
        if (g == 4'd0) return {g[1:0], w[27:16], op, w[11:9], 64'd0, 1'b0};
        return {g[1:0], w[27:16], op, 3'd0, {{52{w[11]}}, w[11:0]}, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; dut_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_q !== 86'd0) begin
            errors++;
            $display("FAIL reset_out_q: got %h expected %h", out_q, 86'd0);
        end
        checks++;
        if (out_q_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_q_valid: got %b expected 0", out_q_valid);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Spec examples with hand-derived expected decodes.
    task automatic test_vectors();
        logic [31:0] words[12];
        logic [85:0] exps[12];
        logic [85:0] e;
        words[0]  = 32'h0123_4A05; exps[0]  = {2'd0, 4'd1, 4'd2, 4'd3, 4'd4, 3'd5, 64'd0, 1'b0};
        words[1]  = 32'h1456_2FFF; exps[1]  = {2'd1, 4'd4, 4'd5, 4'd6, 4'd2, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        words[2]  = 32'h1456_6FFF; exps[2]  = NOP_BUBBLE;
        words[3]  = 32'h0123_DE00; exps[3]  = {2'd0, 4'd1, 4'd2, 4'd3, 4'd13, 3'd7, 64'd0, 1'b0};
        words[4]  = 32'h0123_E000; exps[4]  = NOP_BUBBLE;
        words[5]  = 32'h0123_F000; exps[5]  = NOP_BUBBLE;
        words[6]  = 32'h2123_F7FF; exps[6]  = {2'd2, 4'd1, 4'd2, 4'd3, 4'd15, 3'd0, 64'h0000_0000_0000_07FF, 1'b0};
        words[7]  = 32'h3123_F7FF; exps[7]  = {2'd3, 4'd1, 4'd2, 4'd3, 4'd15, 3'd0, 64'h0000_0000_0000_07FF, 1'b0};
        words[8]  = 32'h4000_0000; exps[8]  = NOP_BUBBLE;
        words[9]  = 32'hF000_0000; exps[9]  = NOP_BUBBLE;
        words[10] = 32'h0000_0000; exps[10] = 86'd0;
        words[11] = 32'h1987_5800; exps[11] = {2'd1, 4'd9, 4'd8, 4'd7, 4'd5, 3'd0, 64'hFFFF_FFFF_FFFF_F800, 1'b0};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            dut_in = words[i];
            exp_q.push_back(exps[i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL vector_%0d in=%h: got %h expected %h", i, words[i], out, e);
            end
        end
    endtask

    task automatic test_random_comb();
        logic [31:0] w;
        logic [85:0] e;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            w = $urandom;
            // Bias toward legal groups so opcode limits get exercised.
            if (i % 2 == 0) w[31:30] = 2'b00;
            dut_in = w;
            in_valid = 1'b0;
            exp_q.push_back(model(w));
            #1;
            e = exp_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL random_comb in=%h: got %h expected %h", w, out, e);
            end
        end
    endtask

    task automatic test_registered();
        logic [85:0] e;
        e = {2'd3, 4'hA, 4'hB, 4'hC, 4'hF, 3'd0, 64'hFFFF_FFFF_FFFF_F800, 1'b0};
        @(negedge clk);
        dut_in = 32'h3ABC_F800;
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_q !== e || out_q_valid !== 1'b1) begin
            errors++;
            $display("FAIL reg_capture: got %h/%b expected %h/1", out_q, out_q_valid, e);
        end
        @(negedge clk);
        dut_in = 32'h0123_4A05;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_q !== e || out_q_valid !== 1'b0) begin
            errors++;
            $display("FAIL reg_hold: got %h/%b expected %h/0", out_q, out_q_valid, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic [85:0] held;
        logic        v;
        held = out_q;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            w = $urandom;
            if (i % 3 != 0) w[31:30] = 2'b00;
            v = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
            dut_in = w;
            in_valid = v;
            if (v) exp_q.push_back(model(w));
            @(posedge clk); #1;
            if (v) held = exp_q.pop_front();
            checks++;
            if (out_q !== held || out_q_valid !== v) begin
                errors++;
                $display("FAIL back_to_back_%0d: got %h/%b expected %h/%b", i, out_q, out_q_valid, held, v);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        logic [85:0] e;
        @(negedge clk);
        dut_in = 32'h1456_2FFF;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_q !== 86'd0 || out_q_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_priority: got %h/%b expected 0/0", out_q, out_q_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        dut_in = 32'h2123_F7FF;
        in_valid = 1'b1;
        e = {2'd2, 4'd1, 4'd2, 4'd3, 4'd15, 3'd0, 64'h0000_0000_0000_07FF, 1'b0};
        @(posedge clk); #1;
        checks++;
        if (out_q !== e || out_q_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_capture: got %h/%b expected %h/1", out_q, out_q_valid, e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        dut_in = 32'h0;
        test_reset();
        test_vectors();
        test_random_comb();
        test_registered();
        test_back_to_back();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
